// File: rtl/seq_stage_ctrl.sv
// Multi-cycle sequencer for the Y86 SEQ datapath: walks FETCH..PCUPD per instruction,
// handshakes with data memory, and tracks the Y86 status code plus cycle/instruction counts.
module seq_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             instr_valid,
  input  logic             dmem_error,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WB, S_PCUPD, S_HALT, S_ERR
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [2:0]      stat_q, stat_d;
  logic [3:0]      icode_q, icode_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            clr_cnt, retire, mem_icode;

  assign mem_icode = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    wait_d  = wait_q;
    clr_cnt = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        stat_d  = STAT_AOK;
        clr_cnt = 1'b1;
      end
      S_FETCH: begin
        icode_d = icode;
        if (imem_error) begin
          state_d = S_ERR;
          stat_d  = STAT_ADR;
        end else if (!instr_valid || icode > 4'hB) begin
          state_d = S_ERR;
          stat_d  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_d = S_HALT;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        wait_d  = '0;
        state_d = mem_icode ? S_MEMORY : S_WB;
      end
      // Ready outranks timeout, so a response in the last allowed cycle is taken.
      S_MEMORY: begin
        if (mem_ready) begin
          if (dmem_error) begin
            state_d = S_ERR;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
          state_d = S_ERR;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT, S_ERR: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      stat_q    <= STAT_AOK;
      icode_q   <= '0;
      wait_q    <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      wait_q  <= wait_d;
      if (clr_cnt) begin
        cycle_cnt <= '0;
        instr_cnt <= '0;
      end else begin
        if (busy && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (retire && instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  assign fetch_en   = (state_q == S_FETCH);
  assign decode_en  = (state_q == S_DECODE);
  assign execute_en = (state_q == S_EXECUTE);
  assign memory_en  = (state_q == S_MEMORY);
  assign wb_en      = (state_q == S_WB);
  assign pc_en      = (state_q == S_PCUPD);
  assign mem_req    = (state_q == S_MEMORY);
  assign busy       = fetch_en | decode_en | execute_en | memory_en | wb_en | pc_en;
  assign stat       = stat_q;

endmodule
